matrix_operand_sequencer: RTL and testbench

- Parametrised successor to the fixed 2x2 / 3-bit operand selector.
- Latches an NxN matrix of EW-bit elements on `start`, then streams the operand sequence for a full matrix product over a valid/ready handshake.
- A `operand_b` control chooses between left-operand order and right-operand order.
- Two instances (one per operand) feed the multiply-accumulate datapath in lockstep.

---
 rtl/matrix_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_matrix_operand_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_sequencer.sv
// matrix_operand_sequencer
// Latches an NxN matrix of EW-bit elements on start, then streams the
// operand sequence of a full matrix product (i, j outer, k fastest) over a
// valid/ready handshake. operand_b selects M[i][k] (0) or M[k][j] (1).
// Optional build macro: MATSEQ_BACK_TO_BACK_EN (restart on the final beat).
module matrix_operand_sequencer #(
  parameter int N  = 2,
  parameter int EW = 3,
  localparam int IW = (N * N * N > 2) ? $clog2(N * N * N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              operand_b,
  input  logic [N*N*EW-1:0] matrix,
  output logic [EW-1:0]     elem_out,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [IW-1:0]     entry_idx,
  output logic              last_k,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       i_q, j_q, k_q;
  logic [N*N*EW-1:0]   mat_q;
  logic                opb_q;
  logic                done_q;
  logic                xfer, load, fin, last_beat;
  int unsigned         sel;

  assign elem_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = done_q;
  assign xfer       = elem_valid & elem_ready;
  assign last_k     = (k_q == C_MAX);
  assign last_beat  = (i_q == C_MAX) && (j_q == C_MAX) && (k_q == C_MAX);
  assign last       = last_beat;
  assign entry_idx  = IW'(32'(i_q) * N * N + 32'(j_q) * N + 32'(k_q));

  // Element select from the latched matrix register
  always_comb begin
    sel      = opb_q ? (32'(k_q) * N + 32'(j_q)) : (32'(i_q) * N + 32'(k_q));
    elem_out = '0;
    for (int unsigned e = 0; e < N * N; e++) begin
      if (e == sel) elem_out = mat_q[e*EW +: EW];
    end
  end

  // Next-state decode plus load / final-transfer strobes
  always_comb begin
    state_d = state;
    load    = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer && last_beat) begin
          fin     = 1'b1;
          state_d = DONE;
`ifdef MATSEQ_BACK_TO_BACK_EN
          // Restart folds into the final transfer: done still pulses for
          // the completed run while the FSM stays in RUN.
          if (start) begin
            load    = 1'b1;
            state_d = RUN;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands and i/j/k counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      mat_q  <= '0;
      opb_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= fin;
      if (load) begin
        mat_q <= matrix;
        opb_q <= operand_b;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
      end else if (xfer) begin
        if (k_q == C_MAX) begin
          k_q <= '0;
          if (j_q == C_MAX) begin
            j_q <= '0;
            i_q <= (i_q == C_MAX) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Testbench for matrix_operand_sequencer: table vectors, hand sequences for
// backpressure / mid-run events / restart, randomized runs against a model,
// and an N=3, EW=8 instance.
module tb_matrix_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, operand_b, elem_ready;
  logic [11:0] matrix;
  logic [2:0]  elem_out;
  logic        elem_valid, last_k, last, busy, done;
  logic [2:0]  entry_idx;

  logic        start3, opb3, ready3;
  logic [71:0] matrix3;
  logic [7:0]  elem_out3;
  logic        valid3, last_k3, last3, busy3, done3;
  logic [4:0]  entry_idx3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  matrix_operand_sequencer #(.N(2), .EW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .operand_b(operand_b), .matrix(matrix),
    .elem_out(elem_out), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .entry_idx(entry_idx), .last_k(last_k), .last(last), .busy(busy), .done(done)
  );

  matrix_operand_sequencer #(.N(3), .EW(8)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .operand_b(opb3), .matrix(matrix3),
    .elem_out(elem_out3), .elem_valid(valid3), .elem_ready(ready3),
    .entry_idx(entry_idx3), .last_k(last_k3), .last(last3), .busy(busy3), .done(done3)
  );

  typedef struct {
    logic        opb;
    logic [11:0] mat;
    logic [23:0] exp_seq;  // beat b expected at bits [b*3 +: 3]
  } vec_t;

  vec_t vecs[4];

  localparam logic [11:0] MAT_A = 12'b100_011_010_001;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected operand for beat b, derived from the (i,j,k) decomposition
  function automatic int model(input logic [127:0] m, input int n, input int ew,
                               input logic ob, input int b);
    int i, j, k, r, c;
    i = b / (n * n);
    j = (b / n) % n;
    k = b % n;
    r = ob ? k : i;
    c = ob ? j : k;
    return int'((m >> ((r * n + c) * ew)) & ((128'd1 << ew) - 1));
  endfunction

  task automatic start_run(input logic [11:0] m, input logic ob);
    @(negedge clk);
    matrix = m; operand_b = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] lat_m;
    logic        lat_ob;
    int          b, cyc;

    vecs[0] = '{1'b0, MAT_A, {3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd1}};
    vecs[1] = '{1'b1, MAT_A, {3'd4, 3'd2, 3'd3, 3'd1, 3'd4, 3'd2, 3'd3, 3'd1}};
    vecs[2] = '{1'b0, 12'b110_101_000_111, {3'd6, 3'd5, 3'd6, 3'd5, 3'd0, 3'd7, 3'd0, 3'd7}};
    vecs[3] = '{1'b1, 12'b110_101_000_111, {3'd6, 3'd0, 3'd5, 3'd7, 3'd6, 3'd0, 3'd5, 3'd7}};

    rst = 1'b1; start = 1'b0; operand_b = 1'b0; elem_ready = 1'b1; matrix = '0;
    start3 = 1'b0; opb3 = 1'b0; ready3 = 1'b1; matrix3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_elem_out", int'(elem_out), 0);
    chk("rst_valid", int'(elem_valid), 0);
    chk("rst_idx", int'(entry_idx), 0);
    chk("rst_last_k", int'(last_k), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // Table-driven zero-wait runs
    foreach (vecs[v]) begin
      logic [23:0] es;
      es = vecs[v].exp_seq;
      start_run(vecs[v].mat, vecs[v].opb);
      for (int bb = 0; bb < 8; bb++) begin
        chk("tbl_elem", int'(elem_out), int'(es[bb*3 +: 3]));
        chk("tbl_idx", int'(entry_idx), bb);
        chk("tbl_valid", int'(elem_valid), 1);
        chk("tbl_busy", int'(busy), 1);
        chk("tbl_last_k", int'(last_k), (bb % 2 == 1) ? 1 : 0);
        chk("tbl_last", int'(last), (bb == 7) ? 1 : 0);
        chk("tbl_done_low", int'(done), 0);
        @(negedge clk);
      end
      chk("tbl_done", int'(done), 1);
      chk("tbl_done_busy", int'(busy), 0);
      chk("tbl_done_valid", int'(elem_valid), 0);
      @(negedge clk);
      chk("tbl_done_pulse", int'(done), 0);
    end

    // Backpressure: ready low for 3 cycles while idx 2 is presented
    start_run(MAT_A, 1'b0);
    cyc = 1;
    while (cyc <= 20 && !done) begin
      if (cyc >= 3 && cyc <= 6) begin
        chk("bp_hold_idx", int'(entry_idx), 2);
        chk("bp_hold_elem", int'(elem_out), 1);
      end
      elem_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      cyc++;
    end
    chk("bp_done_cycle", cyc, 12);
    elem_ready = 1'b1;
    @(negedge clk);

    // Mid-run start ignored, then mid-run reset aborts without done
    start_run(MAT_A, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; matrix = 12'hFFF; operand_b = 1'b1;
    chk("mid_elem4", int'(elem_out), 3);
    chk("mid_idx4", int'(entry_idx), 4);
    @(negedge clk);
    chk("mid_elem5", int'(elem_out), 4);
    chk("mid_idx5", int'(entry_idx), 5);
    @(negedge clk);
    chk("mid_elem6", int'(elem_out), 3);
    chk("mid_idx6", int'(entry_idx), 6);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_elem", int'(elem_out), 0);
    chk("mrst_valid", int'(elem_valid), 0);
    chk("mrst_idx", int'(entry_idx), 0);
    chk("mrst_last_k", int'(last_k), 0);
    chk("mrst_last", int'(last), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mrst_no_done", int'(done), 0);
      chk("mrst_idle", int'(elem_valid), 0);
    end

    // Start during the final beat
    start_run(MAT_A, 1'b0);
    repeat (7) @(negedge clk);
    chk("b2b_idx7", int'(entry_idx), 7);
    start = 1'b1; matrix = 12'hFFF;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", int'(done), 1);
`ifdef MATSEQ_BACK_TO_BACK_EN
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_idx0", int'(entry_idx), 0);
    chk("b2b_elem", int'(elem_out), 7);
`else
    chk("b2b_busy", int'(busy), 0);
    chk("b2b_valid", int'(elem_valid), 0);
    @(negedge clk);
    chk("b2b_valid_after", int'(elem_valid), 0);
    @(negedge clk);
    chk("b2b_still_idle", int'(elem_valid), 0);
`endif
    do_reset();

    // Randomized runs: random ready, input churn during the run
    for (int run = 0; run < 20; run++) begin
      lat_m = 12'($urandom);
      lat_ob = 1'($urandom);
      start_run(lat_m, lat_ob);
      b = 0;
      cyc = 0;
      while (b < 8 && cyc < 200) begin
        chk("rnd_valid", int'(elem_valid), 1);
        chk("rnd_elem", int'(elem_out), model(128'(lat_m), 2, 3, lat_ob, b));
        chk("rnd_idx", int'(entry_idx), b);
        elem_ready = 1'($urandom);
        matrix = 12'($urandom);
        operand_b = 1'($urandom);
        start = (b == 7) ? 1'b0 : 1'($urandom);
        if (elem_ready) b++;
        @(negedge clk);
        cyc++;
      end
      chk("rnd_finished", b, 8);
      start = 1'b0;
      elem_ready = 1'b1;
      chk("rnd_done", int'(done), 1);
      chk("rnd_done_busy", int'(busy), 0);
      @(negedge clk);
      chk("rnd_done_pulse", int'(done), 0);
    end

    // N=3, EW=8: element (r,c) = 10r+c, right-operand order
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        matrix3[(r*3+c)*8 +: 8] = 8'(10 * r + c);
    @(negedge clk);
    opb3 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int bb = 0; bb < 27; bb++) begin
      chk("n3_elem", int'(elem_out3), 10 * (bb % 3) + ((bb / 3) % 3));
      chk("n3_model", int'(elem_out3), model(128'(matrix3), 3, 8, 1'b1, bb));
      chk("n3_idx", int'(entry_idx3), bb);
      chk("n3_last", int'(last3), (bb == 26) ? 1 : 0);
      chk("n3_last_k", int'(last_k3), (bb % 3 == 2) ? 1 : 0);
      @(negedge clk);
    end
    chk("n3_done", int'(done3), 1);
    chk("n3_busy", int'(busy3), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
